// File: rtl/blaster_engine.sv
// JTAG blaster engine: byte-command driven bit-bang and byte-shift modes over
// up to four TCK/TDO chains sharing TMS/TDI/LED, with a single-entry response slot.
`timescale 1ns/1ps

module blaster_engine #(
  parameter int DIV_W    = 8,
  parameter int N_CHAINS = 1,
  localparam int CHAIN_W = (N_CHAINS > 1) ? $clog2(N_CHAINS) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [DIV_W-1:0]    i_div,
  input  logic [CHAIN_W-1:0]  i_chain_sel,
  input  logic                s_valid,
  input  logic [7:0]          s_data,
  output logic                s_ready,
  output logic                m_valid,
  output logic [7:0]          m_data,
  input  logic                m_ready,
  output logic [N_CHAINS-1:0] o_tck,
  input  logic [N_CHAINS-1:0] i_tdo,
  output logic                o_tms,
  output logic                o_tdi,
  output logic                o_led,
  output logic                o_busy,
  output logic [2:0]          o_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BITBANG = 3'd1,
    S_WAIT  = 3'd2,
    S_LOW   = 3'd3,
    S_HIGH  = 3'd4,
    POST    = 3'd5
  } state_t;

  state_t               state_q;
  logic [N_CHAINS-1:0]  tck_q;
  logic                 tms_q;
  logic                 tdi_q;
  logic                 led_q;
  logic                 m_valid_q;
  logic [7:0]           m_data_q;
  logic                 rdy_en_q;
  logic [5:0]           remain_q;
  logic                 rd_q;
  logic [CHAIN_W-1:0]   sel_q;
  logic [DIV_W-1:0]     phase_q;
  logic [2:0]           bit_q;
  logic [7:0]           tx_q;
  logic [7:0]           rx_q;

  logic [CHAIN_W-1:0]   sel_d;
  logic                 tdo_acc_d;
  logic                 tdo_cur_d;
  logic                 accept_d;
  logic                 needs_slot_d;
  logic                 m_pop_d;

  // Out-of-range chain selects fall back to chain 0.
  function automatic logic [CHAIN_W-1:0] clamp_sel(input logic [CHAIN_W-1:0] s);
    if (int'(s) < N_CHAINS) return s;
    return '0;
  endfunction

  function automatic logic [N_CHAINS-1:0] tck_vec(input logic [CHAIN_W-1:0] s, input logic b);
    logic [N_CHAINS-1:0] v;
    v    = '0;
    v[s] = b;
    return v;
  endfunction

  assign sel_d     = clamp_sel(i_chain_sel);
  assign tdo_acc_d = i_tdo[sel_d];
  assign tdo_cur_d = i_tdo[sel_q];

  // Handshake: a byte moves on the rising edge where valid & ready are both high.
  // A bit-bang read needs the response slot at accept time; shift reads do not,
  // because POST stalls until the slot frees.
  assign needs_slot_d = ~s_data[7] & s_data[6];
  assign s_ready = rdy_en_q &
                   (((state_q == IDLE) & (~m_valid_q | ~needs_slot_d)) |
                    (state_q == S_WAIT));
  assign accept_d = s_valid & s_ready;
  assign m_pop_d  = m_valid_q & m_ready;

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign o_tck   = tck_q;
  assign o_tms   = tms_q;
  assign o_tdi   = tdi_q;
  assign o_led   = led_q;
  assign o_busy  = (state_q != IDLE);
  assign o_state = state_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      tck_q     <= '0;
      tms_q     <= 1'b0;
      tdi_q     <= 1'b0;
      led_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      rdy_en_q  <= 1'b0;
      remain_q  <= 6'd0;
      rd_q      <= 1'b0;
      sel_q     <= '0;
      phase_q   <= '0;
      bit_q     <= 3'd0;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
    end else begin
      rdy_en_q <= 1'b1;
      if (m_pop_d) m_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (accept_d) begin
            if (!s_data[7]) begin
              state_q <= BITBANG;
              tck_q   <= tck_vec(sel_d, s_data[0]);
              tms_q   <= s_data[1];
              tdi_q   <= s_data[4];
              led_q   <= s_data[5];
              if (s_data[6]) begin
                m_valid_q <= 1'b1;
                m_data_q  <= {7'b0, tdo_acc_d};
              end
            end else begin
              remain_q <= s_data[5:0];
              rd_q     <= s_data[6];
              sel_q    <= sel_d;
              state_q  <= (s_data[5:0] == 6'd0) ? IDLE : S_WAIT;
            end
          end
        end

        BITBANG: state_q <= IDLE;

        S_WAIT: begin
          if (accept_d) begin
            tx_q     <= s_data;
            remain_q <= remain_q - 6'd1;
            bit_q    <= 3'd0;
            tdi_q    <= s_data[0];
            tck_q    <= '0;
            phase_q  <= i_div;
            state_q  <= S_LOW;
          end
        end

        S_LOW: begin
          if (phase_q == '0) begin
            // TDO is captured on the edge that raises TCK, filling from the MSB.
            tck_q   <= tck_vec(sel_q, 1'b1);
            rx_q    <= {tdo_cur_d, rx_q[7:1]};
            phase_q <= i_div;
            state_q <= S_HIGH;
          end else begin
            phase_q <= phase_q - 1'b1;
          end
        end

        S_HIGH: begin
          if (phase_q == '0) begin
            tck_q <= '0;
            if (bit_q != 3'd7) begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= tx_q >> 1;
              tdi_q   <= tx_q[1];
              phase_q <= i_div;
              state_q <= S_LOW;
            end else if (rd_q) begin
              state_q <= POST;
            end else begin
              state_q <= (remain_q == 6'd0) ? IDLE : S_WAIT;
            end
          end else begin
            phase_q <= phase_q - 1'b1;
          end
        end

        POST: begin
          if (!m_valid_q || m_ready) begin
            m_valid_q <= 1'b1;
            m_data_q  <= rx_q;
            state_q   <= (remain_q == 6'd0) ? IDLE : S_WAIT;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blaster_engine.sv
// Bench for blaster_engine: scenario tasks with inline checks plus a response
// scoreboard that pops expected bytes on every m_valid/m_ready handshake.
`timescale 1ns/1ps

module tb_blaster_engine;
  localparam int DIV_W = 8;
  localparam int N_CH  = 4;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_BB = 3'd1, ST_POST = 3'd5;

  logic             i_clk = 1'b0;
  logic             i_reset_n = 1'b0;
  logic [DIV_W-1:0] i_div = '0;
  logic [1:0]       i_chain_sel = '0;
  logic             s_valid = 1'b0;
  logic [7:0]       s_data = 8'h00;
  logic             s_ready;
  logic             m_valid;
  logic [7:0]       m_data;
  logic             m_ready = 1'b1;
  logic [N_CH-1:0]  o_tck;
  logic [N_CH-1:0]  i_tdo;
  logic             o_tms, o_tdi, o_led, o_busy;
  logic [2:0]       o_state;

  logic             tdo_lb = 1'b0;
  logic [N_CH-1:0]  tdo_inv = '0;
  logic [N_CH-1:0]  tdo_val = '0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int n_cmp = 0;
  int n_err = 0;

  assign i_tdo = tdo_lb ? ({N_CH{o_tdi}} ^ tdo_inv) : tdo_val;

  blaster_engine #(.DIV_W(DIV_W), .N_CHAINS(N_CH)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_div(i_div), .i_chain_sel(i_chain_sel),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .o_tck(o_tck), .i_tdo(i_tdo), .o_tms(o_tms), .o_tdi(o_tdi), .o_led(o_led),
    .o_busy(o_busy), .o_state(o_state)
  );

  // clock / reset block
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard: a handshake happens at the next rising edge
  always @(negedge i_clk) begin
    if (i_reset_n && m_valid && m_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL resp_unexpected got=%02h want=none", m_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (m_data !== exp_b) begin
          n_err++;
          $display("FAIL resp_data got=%02h want=%02h", m_data, exp_b);
        end
      end
    end
  end

  // driver tasks (entered and left at rising edge + 1)
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    while (!ok && n < 2000) begin
      @(negedge i_clk);
      if (s_ready) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout byte=%02h got=not_accepted want=accepted", b);
    end
    @(posedge i_clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    tick(3);
    n_cmp++;
    if ({o_tck, o_tms, o_tdi, o_led, m_valid, m_data, o_busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b want=0", {o_tck, o_tms, o_tdi, o_led, m_valid, m_data, o_busy});
    end
    n_cmp++;
    if (s_ready !== 1'b0 || o_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_ready_state got=%b/%0d want=0/0", s_ready, o_state);
    end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1;
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_before_clock got=%b want=0", s_ready);
    end
    @(posedge i_clk);
    #1;
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_release got=%b want=1", s_ready);
    end
  endtask

  task automatic test_bitbang();
    m_ready = 1'b1; tdo_lb = 1'b0; tdo_val = 4'hF; i_chain_sel = 2'd0;
    exp_q.push_back(8'h01);
    send_byte(8'h53);
    n_cmp++;
    if ({o_tck, o_tms, o_tdi, o_led} !== 7'b0001_110) begin
      n_err++;
      $display("FAIL bb53_pins got=%b want=0001110", {o_tck, o_tms, o_tdi, o_led});
    end
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'h01 || o_state !== ST_BB || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL bb53_resp got=%b/%02h/%0d want=1/01/1", m_valid, m_data, o_state);
    end
    tick(1);
    n_cmp++;
    if (o_busy !== 1'b0 || o_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL bb_back_idle got=%b/%0d want=0/0", o_busy, o_state);
    end
    tdo_val = 4'h0;
    send_byte(8'h20);
    n_cmp++;
    if ({o_tck, o_tms, o_tdi, o_led, m_valid} !== 8'b0000_0010) begin
      n_err++;
      $display("FAIL bb20_pins got=%b want=00000010", {o_tck, o_tms, o_tdi, o_led, m_valid});
    end
    i_chain_sel = 2'd3;
    send_byte(8'h01);
    n_cmp++;
    if (o_tck !== 4'b1000) begin
      n_err++;
      $display("FAIL bb_chain3 got=%b want=1000", o_tck);
    end
    i_chain_sel = 2'd0;
    send_byte(8'h02);
    n_cmp++;
    if ({o_tck, o_tms} !== 5'b0000_1) begin
      n_err++;
      $display("FAIL bb02_pins got=%b want=00001", {o_tck, o_tms});
    end
  endtask

  task automatic test_shift();
    int rises, bad, other, tms_bad, run, cyc;
    logic prev;
    logic [7:0] tdi_bits;
    i_div = 8'd2; tdo_lb = 1'b1; tdo_inv = '0; m_ready = 1'b1; i_chain_sel = 2'd0;
    rises = 0; bad = 0; other = 0; tms_bad = 0; run = 0; cyc = 0; tdi_bits = '0;
    exp_q.push_back(8'hA5);
    send_byte(8'hC1);
    send_byte(8'hA5);
    prev = o_tck[0];
    while (cyc < 300 && !(rises == 8 && prev == 1'b0 && o_state == ST_IDLE)) begin
      @(negedge i_clk);
      cyc++;
      if (o_tck[3:1] !== 3'b000) other++;
      if (o_tms !== 1'b1) tms_bad++;
      if (o_tck[0] !== prev) begin
        if (prev == 1'b1 && run != 3) bad++;
        if (prev == 1'b0 && rises > 0 && run != 3) bad++;
        if (o_tck[0] == 1'b1) begin
          if (rises < 8) tdi_bits[rises] = o_tdi;
          rises++;
        end
        run = 1;
        prev = o_tck[0];
      end else begin
        run++;
      end
    end
    @(posedge i_clk);
    #1;
    n_cmp++;
    if (rises != 8 || cyc >= 300) begin
      n_err++;
      $display("FAIL shift_pulses got=%0d want=8 (cycles=%0d)", rises, cyc);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL shift_phase_len got=%0d_bad_runs want=0", bad);
    end
    n_cmp++;
    if (tdi_bits !== 8'hA5) begin
      n_err++;
      $display("FAIL shift_tdi_order got=%02h want=a5", tdi_bits);
    end
    n_cmp++;
    if (other != 0 || tms_bad != 0) begin
      n_err++;
      $display("FAIL shift_side_pins got=%0d/%0d want=0/0", other, tms_bad);
    end
  endtask

  task automatic test_zero_len();
    int changes, resp;
    changes = 0; resp = 0;
    i_chain_sel = 2'd0;
    send_byte(8'h01);
    send_byte(8'h80);
    n_cmp++;
    if (o_state !== ST_IDLE || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_idle got=%0d/%b want=0/0", o_state, o_busy);
    end
    repeat (20) begin
      @(negedge i_clk);
      if (o_tck !== 4'b0001) changes++;
      if (m_valid) resp++;
    end
    @(posedge i_clk);
    #1;
    n_cmp++;
    if (changes != 0 || resp != 0) begin
      n_err++;
      $display("FAIL zero_len_quiet got=%0d/%0d want=0/0", changes, resp);
    end
  endtask

  task automatic test_post_stall();
    int cyc;
    i_div = 8'd0; tdo_lb = 1'b1; tdo_inv = '0; m_ready = 1'b0; i_chain_sel = 2'd0;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h96);
    send_byte(8'hC2);
    send_byte(8'h3C);
    send_byte(8'h96);
    cyc = 0;
    while (cyc < 100 && o_state !== ST_POST) begin
      tick(1);
      cyc++;
    end
    n_cmp++;
    if (o_state !== ST_POST || m_valid !== 1'b1 || m_data !== 8'h3C || o_tck !== 4'b0000) begin
      n_err++;
      $display("FAIL post_stall_enter got=%0d/%b/%02h/%b want=5/1/3c/0000", o_state, m_valid, m_data, o_tck);
    end
    tick(10);
    n_cmp++;
    if (o_state !== ST_POST || m_data !== 8'h3C || o_tck !== 4'b0000 || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL post_stall_hold got=%0d/%02h/%b want=5/3c/0000", o_state, m_data, o_tck);
    end
    m_ready = 1'b1;
    cyc = 0;
    while (cyc < 100 && !(o_state == ST_IDLE && m_valid == 1'b0)) begin
      tick(1);
      cyc++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || cyc >= 100) begin
      n_err++;
      $display("FAIL post_resume got=%0d_left want=0", exp_q.size());
    end
  endtask

  task automatic test_chain();
    int rises, other, cyc;
    logic prev;
    i_div = 8'd1; tdo_lb = 1'b1; tdo_inv = 4'b1011; m_ready = 1'b1;
    rises = 0; other = 0; cyc = 0;
    exp_q.push_back(8'h5A);
    i_chain_sel = 2'd2;
    send_byte(8'hC1);
    i_chain_sel = 2'd0;
    send_byte(8'h5A);
    prev = o_tck[2];
    while (cyc < 200 && !(rises == 8 && o_state == ST_IDLE)) begin
      @(negedge i_clk);
      cyc++;
      if ({o_tck[3], o_tck[1:0]} !== 3'b000) other++;
      if (o_tck[2] && !prev) rises++;
      prev = o_tck[2];
    end
    tick(2);
    tdo_inv = '0;
    n_cmp++;
    if (rises != 8 || other != 0) begin
      n_err++;
      $display("FAIL chain2_tck got=%0d_rises/%0d_other want=8/0", rises, other);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    i_div = 8'd3; tdo_lb = 1'b1; tdo_inv = '0; m_ready = 1'b1; i_chain_sel = 2'd0;
    send_byte(8'h22);
    send_byte(8'hBF);
    send_byte(8'hFF);
    cyc = 0;
    while (cyc < 100 && o_tck[0] !== 1'b1) begin
      @(negedge i_clk);
      cyc++;
    end
    #2;
    i_reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_tck, o_tms, o_tdi, o_led, m_valid, m_data, o_busy, s_ready} !== '0 || o_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_async got=%b/%0d want=0/0", {o_tck, o_tms, o_tdi, o_led, m_valid, m_data, o_busy, s_ready}, o_state);
    end
    tick(2);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    tick(1);
    n_cmp++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release got=%b/%b want=1/0", s_ready, m_valid);
    end
    tdo_lb = 1'b0; tdo_val = 4'h0;
    exp_q.push_back(8'h00);
    send_byte(8'h43);
    n_cmp++;
    if ({o_tck, o_tms, o_tdi, o_led, m_valid, m_data} !== 16'b0001_1001_0000_0000) begin
      n_err++;
      $display("FAIL after_reset_cmd got=%b want=0001100100000000", {o_tck, o_tms, o_tdi, o_led, m_valid, m_data});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic [1:0] s;
    logic [3:0] e;
    m_ready = 1'b1; tdo_lb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b = 8'h40 | 8'($urandom_range(0, 63));
      s = 2'($urandom_range(0, 3));
      tdo_val = 4'($urandom_range(0, 15));
      i_chain_sel = s;
      e = '0;
      e[s] = b[0];
      exp_q.push_back({7'b0, tdo_val[s]});
      send_byte(b);
      n_cmp++;
      if (o_tck !== e || o_tms !== b[1] || o_led !== b[5]) begin
        n_err++;
        $display("FAIL b2b_pins byte=%02h got=%b/%b/%b want=%b/%b/%b", b, o_tck, o_tms, o_led, e, b[1], b[5]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bitbang();
    test_shift();
    test_zero_len();
    test_post_stall();
    test_chain();
    test_reset_mid();
    test_back_to_back();
    tick(5);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_queue got=%0d_left want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/blaster_engine.md
BLASTER_ENGINE -- requirements
Module: blaster_engine

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of the TCK half-period divider input.
REQ-002 SHALL have parameter N_CHAINS, default 1, legal 1..4: number of independent JTAG TCK/TDO chains; CHAIN_W = max(1, clog2(N_CHAINS)).
REQ-003 SHALL have port i_clk  input  1: clock; all logic on rising edge.
REQ-004 SHALL have port i_reset_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_div  input  DIV_W: TCK half-period minus one, in i_clk cycles.
REQ-006 SHALL have port i_chain_sel  input  CHAIN_W: target chain, sampled at command accept.
REQ-007 SHALL have ports s_valid input 1, s_data input 8, s_ready output 1: command/payload byte stream in.
REQ-008 SHALL have ports m_valid output 1, m_data output 8, m_ready input 1: response byte stream out.
REQ-009 SHALL have ports o_tck output N_CHAINS, i_tdo input N_CHAINS: per-chain clock out, data in.
REQ-010 SHALL have ports o_tms, o_tdi, o_led output 1 each: shared to all chains.
REQ-011 SHALL have port o_busy output 1: high in every state except IDLE.

Function
REQ-012 SHALL transfer a byte only on s_valid & s_ready; same rule on m_valid & m_ready.
REQ-013 SHALL implement states IDLE, BITBANG, S_WAIT, S_LOW, S_HIGH, POST.
REQ-014 SHALL assert s_ready only in IDLE and S_WAIT, and only when m_valid is 0 or a pending response needs no slot.
REQ-015 SHALL, on accepted byte in IDLE with bit7=0, enter BITBANG for one cycle: o_tck[sel]=d[0], o_tms=d[1], o_tdi=d[4], o_led=d[5]; unselected o_tck bits held 0.
REQ-016 SHALL, in bit-bang with d[6]=1, sample i_tdo[sel] in the accept cycle (before new outputs) and post m_data={7'b0,tdo} with m_valid=1 one cycle after accept.
REQ-017 SHALL, on accepted byte in IDLE with bit7=1, latch N=d[5:0], read flag R=d[6], chain sel; N=0 returns to IDLE with no TCK activity and no response.
REQ-018 SHALL, for N>0, enter S_WAIT and accept exactly N payload bytes, each shifted LSB first as 8 TCK pulses.
REQ-019 SHALL drive each bit as: S_LOW for i_div+1 cycles with o_tck[sel]=0 and o_tdi=bit set on entry; S_HIGH for i_div+1 cycles with o_tck[sel]=1.
REQ-020 SHALL sample i_tdo[sel] on the cycle o_tck[sel] rises, shifting into an 8-bit register from MSB (shift right).
REQ-021 SHALL latch i_div at the start of every phase; mid-phase changes take effect next phase.
REQ-022 SHALL hold o_tms and o_led at their last bit-bang values throughout shift mode.
REQ-023 SHALL, after bit 7's high phase, drive o_tck[sel]=0; if R=1 go POST, else S_WAIT (bytes remaining) or IDLE (N exhausted).
REQ-024 SHALL in POST set m_valid=1, m_data=captured byte; if m_valid already pending and m_ready=0, stall in POST (TCK held low) until the slot frees.
REQ-025 SHALL hold m_valid and m_data stable until m_ready; single-entry output register.
REQ-026 SHALL keep the 6-bit remaining counter exact for N=63 (no wrap); decrement once per accepted payload byte.
REQ-027 SHALL ignore i_chain_sel values >= N_CHAINS by targeting chain 0.
REQ-028 SHALL produce TCK frequency f_clk / (2*(i_div+1)); i_div=0 gives f_clk/2.

Reset
REQ-029 SHALL, on i_reset_n=0, immediately force state IDLE, o_tck=0, o_tms=0, o_tdi=0, o_led=0, m_valid=0, m_data=0, s_ready=0, o_busy=0, counters 0.
REQ-030 SHALL abort any in-flight shift on reset with no response emitted; s_ready=1 from the first clock after release.

Verification
REQ-031 SHALL verify: bit-bang 0x53 with i_tdo=1 -> tck=1, tms=1, tdi=1, led=0; m_data=0x01 one cycle later.
REQ-032 SHALL verify: header 0xC1, payload 0xA5, i_div=2, i_tdo loopback of o_tdi -> 8 pulses each 3 low/3 high, m_data=0xA5.
REQ-033 SHALL verify: header 0x80 -> no TCK edges, no response, IDLE next cycle.
REQ-034 SHALL verify: header 0xC2, m_ready=0 throughout -> first byte posted, engine stalls in POST after byte 2, TCK low, resumes on m_ready=1.
REQ-035 SHALL verify: N_CHAINS=4, i_chain_sel=2 -> only o_tck[2] toggles; i_tdo[2] captured, other i_tdo ignored.
REQ-036 SHALL verify: reset asserted mid-bit of header 0xBF -> outputs zero asynchronously, m_valid=0, next command after release executes correctly.
